// File: rtl/wm8731_pkg.sv
// Shared definitions for the WM8731 control-port responder: FSM states,
// default device address and the shadow register reset table.
package wm8731_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ACK_A,
      BYTE1,
      ACK_1,
      BYTE2,
      ACK_2,
      IGNORE
   } state_t;

   localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h1A;
   localparam int         NUM_REGS         = 10;
   localparam logic [6:0] REG_RESET_ALL    = 7'h0F;

   localparam logic [8:0] SHADOW_DEFAULTS [NUM_REGS] = '{
      9'h097, 9'h097, 9'h079, 9'h079, 9'h00A,
      9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000
   };

endpackage

// File: rtl/i2c_line_sync.sv
// Brings SCL/SDA into the i_clk domain and flags SCL edges plus START/STOP
// conditions on the synchronized lines.
module i2c_line_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_scl,
   input  logic i_sda,
   output logic o_sda,
   output logic o_scl_rise,
   output logic o_scl_fall,
   output logic o_start,
   output logic o_stop
);

   logic [SYNC_STAGES-1:0] scl_ff;
   logic [SYNC_STAGES-1:0] sda_ff;
   logic                   scl_s;
   logic                   scl_q;
   logic                   sda_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         scl_ff <= '1;
         sda_ff <= '1;
         scl_q  <= 1'b1;
         sda_q  <= 1'b1;
      end else begin
         scl_ff[0] <= i_scl;
         sda_ff[0] <= i_sda;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            scl_ff[i] <= scl_ff[i-1];
            sda_ff[i] <= sda_ff[i-1];
         end
         scl_q <= scl_s;
         sda_q <= o_sda;
      end
   end

   assign scl_s = scl_ff[SYNC_STAGES-1];
   assign o_sda = sda_ff[SYNC_STAGES-1];

   assign o_scl_rise = scl_s & ~scl_q;
   assign o_scl_fall = ~scl_s & scl_q;
   // SCL must be high on both sides of the SDA transition
   assign o_start    = scl_s & scl_q & sda_q & ~o_sda;
   assign o_stop     = scl_s & scl_q & ~sda_q & o_sda;

endmodule

// File: rtl/wm8731_i2c_responder.sv
// Write-only I2C control-port responder for the WM8731 codec: decodes
// {reg, data} word writes into a shadow register file.
//
// state  | meaning
// IDLE   | bus free or ignored until the next START
// ADDR   | shifting in the address byte
// ACK_A  | pulling SDA low to ACK the address
// BYTE1  | shifting in {reg[6:0], data[8]}
// ACK_1  | ACK of byte 1
// BYTE2  | shifting in data[7:0]
// ACK_2  | ACK of byte 2; the write commits on entry
// IGNORE | not addressed or frame complete; NACK until STOP/START
module wm8731_i2c_responder
   import wm8731_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR    = DEV_ADDR_DEFAULT,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_scl,
   input  logic       i_sda,
   output logic       o_sda_oe,
   output logic       o_wr_valid,
   output logic [6:0] o_wr_addr,
   output logic [8:0] o_wr_data,
   input  logic [3:0] i_rd_addr,
   output logic [8:0] o_rd_data,
   output logic       o_busy,
   output logic [7:0] o_wr_count
);

   logic       sda_s;
   logic       scl_rise;
   logic       scl_fall;
   logic       start_det;
   logic       stop_det;

   state_t     state_q;
   logic [2:0] bit_cnt_q;
   logic       byte_done_q;
   logic [7:0] shift_q;
   logic [7:0] byte1_q;
   logic       sda_oe_q;
   logic [8:0] shadow_q [NUM_REGS];

   logic       in_byte;
   logic       byte_end;
   logic [6:0] commit_reg;
   logic [8:0] commit_data;

   i2c_line_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_line_sync (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_scl      (i_scl),
      .i_sda      (i_sda),
      .o_sda      (sda_s),
      .o_scl_rise (scl_rise),
      .o_scl_fall (scl_fall),
      .o_start    (start_det),
      .o_stop     (stop_det)
   );

   assign in_byte     = (state_q == ADDR) || (state_q == BYTE1) || (state_q == BYTE2);
   assign byte_end    = in_byte && scl_fall && byte_done_q;
   assign commit_reg  = byte1_q[7:1];
   assign commit_data = {byte1_q[0], shift_q};

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= IDLE;
         bit_cnt_q   <= 3'd7;
         byte_done_q <= 1'b0;
         shift_q     <= '0;
         byte1_q     <= '0;
         sda_oe_q    <= 1'b0;
         o_wr_valid  <= 1'b0;
         o_wr_addr   <= '0;
         o_wr_data   <= '0;
         o_busy      <= 1'b0;
         o_wr_count  <= '0;
         shadow_q    <= SHADOW_DEFAULTS;
      end else begin
         o_wr_valid <= 1'b0;
         if (start_det) begin
            state_q     <= ADDR;
            o_busy      <= 1'b1;
            sda_oe_q    <= 1'b0;
            bit_cnt_q   <= 3'd7;
            byte_done_q <= 1'b0;
         end else if (stop_det) begin
            state_q     <= IDLE;
            o_busy      <= 1'b0;
            sda_oe_q    <= 1'b0;
            bit_cnt_q   <= 3'd7;
            byte_done_q <= 1'b0;
         end else begin
            // bit counter wraps 0 -> 7 on the 8th bit, ready for the next byte
            if (in_byte && scl_rise) begin
               shift_q     <= {shift_q[6:0], sda_s};
               bit_cnt_q   <= bit_cnt_q - 3'd1;
               byte_done_q <= (bit_cnt_q == 3'd0);
            end
            case (state_q)
               ADDR: begin
                  if (byte_end) begin
                     byte_done_q <= 1'b0;
                     if ((shift_q[7:1] == DEV_ADDR) && !shift_q[0]) begin
                        state_q  <= ACK_A;
                        sda_oe_q <= 1'b1;
                     end else begin
                        state_q  <= IGNORE;
                     end
                  end
               end
               ACK_A: begin
                  if (scl_fall) begin
                     sda_oe_q <= 1'b0;
                     state_q  <= BYTE1;
                  end
               end
               BYTE1: begin
                  if (byte_end) begin
                     byte_done_q <= 1'b0;
                     byte1_q     <= shift_q;
                     sda_oe_q    <= 1'b1;
                     state_q     <= ACK_1;
                  end
               end
               ACK_1: begin
                  if (scl_fall) begin
                     sda_oe_q <= 1'b0;
                     state_q  <= BYTE2;
                  end
               end
               BYTE2: begin
                  if (byte_end) begin
                     byte_done_q <= 1'b0;
                     sda_oe_q    <= 1'b1;
                     state_q     <= ACK_2;
                     o_wr_valid  <= 1'b1;
                     o_wr_addr   <= commit_reg;
                     o_wr_data   <= commit_data;
                     o_wr_count  <= o_wr_count + 8'd1;
                     if (commit_reg == REG_RESET_ALL) begin
                        shadow_q <= SHADOW_DEFAULTS;
                     end else begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                           if (commit_reg == 7'(i)) shadow_q[i] <= commit_data;
                        end
                     end
                  end
               end
               ACK_2: begin
                  if (scl_fall) begin
                     sda_oe_q <= 1'b0;
                     state_q  <= IGNORE;
                  end
               end
               default: sda_oe_q <= 1'b0;
            endcase
         end
      end
   end

   // reset lets go of SDA immediately rather than one clock later
   assign o_sda_oe = sda_oe_q & ~i_rst;

   always_comb begin
      o_rd_data = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (i_rd_addr == 4'(i)) o_rd_data = shadow_q[i];
      end
   end

endmodule
